prio_enc_seq: RTL and testbench



---
 rtl/prio_enc_seq.sv | 140 ++++++++++++++
 tb/tb_prio_enc_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_seq.sv
// ---------------------------------------------------------------------------
// prio_enc_seq
//
// Sequential priority encoder. A WIDTH-bit request vector is captured on an
// accepted Load while idle, then handed out one index per Valid/Ready
// handshake in priority order until every set bit has been served. A
// one-cycle Done pulse marks the end of each burst, including empty loads.
//
// Build option:
//   PRIO_MSB_FIRST_EN  defined   -> highest set index wins (descending drain)
//                      undefined -> lowest set index wins (ascending drain)
//
// Ports:
//   CLK    in   1         clock, rising edge
//   RST_N  in   1         asynchronous active-low reset
//   EN     in   1         global enable, low freezes all state
//   Load   in   1         capture strobe, honoured only while idle
//   In     in   WIDTH     request vector, sampled on an accepted Load
//   Ready  in   1         consumer takes the current Y
//   Y      out  IDXW      index of the highest-priority pending request
//   Valid  out  1         Y carries a real index
//   Busy   out  1         burst in progress
//   Done   out  1         one-cycle pulse after a burst completes
//   Cnt    out  IDXW+1    indices accepted in the current or last burst
// ---------------------------------------------------------------------------
module prio_enc_seq #(
  parameter  int WIDTH = 8,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              Load,
  input  logic [WIDTH-1:0]  In,
  input  logic              Ready,
  output logic [IDXW-1:0]   Y,
  output logic              Valid,
  output logic              Busy,
  output logic              Done,
  output logic [IDXW:0]     Cnt
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pend_q,  pend_d;
  logic [IDXW:0]     cnt_q,   cnt_d;
  logic              done_q,  done_d;

  logic [IDXW-1:0]   selIdx;
  logic [WIDTH-1:0]  selMask;
  logic [WIDTH-1:0]  pendAfter;
  logic              accept;

  // Index select over the pending set. The loop direction makes the last
  // match the winner, so the scan order alone decides which end has priority.
  always_comb begin
    selIdx = '0;
`ifdef PRIO_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (pend_q[i]) selIdx = IDXW'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend_q[i]) selIdx = IDXW'(i);
    end
`endif
  end

  // Pending set as it will look once the current index is taken; an empty
  // result means this handshake finishes the burst.
  always_comb begin
    selMask   = {{(WIDTH-1){1'b0}}, 1'b1} << selIdx;
    pendAfter = pend_q & ~selMask;
    accept    = Valid && Ready;
  end

  // State and datapath registers. Done is registered so that a pulse already
  // scheduled still fires even if EN drops in the meantime.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. With EN low nothing is accepted in either state, so
  // every register simply holds and no new Done is scheduled.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (EN && Load) begin
          pend_d = In;
          cnt_d  = '0;
          if (|In) begin
            state_d = SCAN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (accept) begin
          pend_d = pendAfter;
          cnt_d  = cnt_q + {{IDXW{1'b0}}, 1'b1};
          if (pendAfter == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state and EN, never on In, so the
  // consumer never sees a combinational path from the request bank.
  always_comb begin
    Busy  = (state_q == SCAN);
    Valid = (state_q == SCAN) && EN && (pend_q != '0);
    Y     = Valid ? selIdx : '0;
    Done  = done_q;
    Cnt   = cnt_q;
  end

endmodule

// File: tb/tb_prio_enc_seq.sv
// ---------------------------------------------------------------------------
// tb_prio_enc_seq
//
// Directed bench for prio_enc_seq. An 8-bit instance walks through reset,
// empty load, full drain, backpressure, EN freeze with an ignored Load, and
// reset mid-burst followed by a re-load. A 16-bit instance checks the drain
// order, which follows the PRIO_MSB_FIRST_EN build option.
// ---------------------------------------------------------------------------
module tb_prio_enc_seq;

  logic        CLK;
  logic        RST_N;
  logic        EN;
  logic        Load;
  logic [7:0]  In;
  logic        Ready;
  logic [2:0]  Y;
  logic        Valid;
  logic        Busy;
  logic        Done;
  logic [3:0]  Cnt;

  logic        en16;
  logic        load16;
  logic [15:0] in16;
  logic        ready16;
  logic [3:0]  y16;
  logic        valid16;
  logic        busy16;
  logic        done16;
  logic [4:0]  cnt16;

  int total;
  int bad;

  prio_enc_seq #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (EN),
    .Load  (Load),
    .In    (In),
    .Ready (Ready),
    .Y     (Y),
    .Valid (Valid),
    .Busy  (Busy),
    .Done  (Done),
    .Cnt   (Cnt)
  );

  prio_enc_seq #(.WIDTH(16)) dut16 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (en16),
    .Load  (load16),
    .In    (in16),
    .Ready (ready16),
    .Y     (y16),
    .Valid (valid16),
    .Busy  (busy16),
    .Done  (done16),
    .Cnt   (cnt16)
  );

  // Free-running 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single comparison point: counts every check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drives the 8-bit instance's inputs for the coming cycle.
  task automatic applyStimulus(input logic en, input logic load,
                               input logic [7:0] inVec, input logic ready);
    EN    = en;
    Load  = load;
    In    = inVec;
    Ready = ready;
  endtask

  // Advance to 1 ns after the next rising edge; inputs are then changed and
  // outputs sampled well away from the edge.
  task automatic nextCycle;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int yExp[4];
    int bpY[5];
    logic bpReady[5];
    int y16Exp[3];

    total = 0;
    bad   = 0;
    RST_N = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    en16 = 1'b1; load16 = 1'b0; in16 = 16'h0000; ready16 = 1'b0;

    // Reset state
    #2;
    checkOutput("rst_y",     32'(Y),     0);
    checkOutput("rst_valid", 32'(Valid), 0);
    checkOutput("rst_busy",  32'(Busy),  0);
    checkOutput("rst_done",  32'(Done),  0);
    checkOutput("rst_cnt",   32'(Cnt),   0);
    nextCycle();
    RST_N = 1'b1;
    nextCycle();

    // Empty load: Done one cycle later, Cnt 0, never Valid
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);
    #1 checkOutput("empty_valid_pre", 32'(Valid), 0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    checkOutput("empty_done",  32'(Done),  1);
    checkOutput("empty_cnt",   32'(Cnt),   0);
    checkOutput("empty_valid", 32'(Valid), 0);
    checkOutput("empty_busy",  32'(Busy),  0);
    nextCycle();
    checkOutput("empty_done_end", 32'(Done),  0);
    checkOutput("empty_valid2",   32'(Valid), 0);

    // Full drain of 1010_0110 with Ready held: 1,2,5,7
    yExp = '{1, 2, 5, 7};
    applyStimulus(1'b1, 1'b1, 8'b1010_0110, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("drain_y%0d", k), 32'(Y), 32'(yExp[k]));
      checkOutput($sformatf("drain_valid%0d", k), 32'(Valid), 1);
      checkOutput($sformatf("drain_done%0d", k), 32'(Done), 0);
      nextCycle();
    end
    checkOutput("drain_done",  32'(Done),  1);
    checkOutput("drain_cnt",   32'(Cnt),   4);
    checkOutput("drain_valid", 32'(Valid), 0);
    checkOutput("drain_busy",  32'(Busy),  0);

    // Backpressure, loaded in the Done cycle: 8'h81 with Ready 0,1,0,0,1
    bpReady = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bpY     = '{0, 0, 7, 7, 7};
    applyStimulus(1'b1, 1'b1, 8'h81, 1'b0);
    nextCycle();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, bpReady[k]);
      #1;
      checkOutput($sformatf("bp_y%0d", k), 32'(Y), 32'(bpY[k]));
      checkOutput($sformatf("bp_valid%0d", k), 32'(Valid), 1);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    checkOutput("bp_done",  32'(Done),  1);
    checkOutput("bp_cnt",   32'(Cnt),   2);
    checkOutput("bp_valid", 32'(Valid), 0);
    nextCycle();

    // EN freeze mid-burst plus an ignored Load of 8'hFF while busy
    applyStimulus(1'b1, 1'b1, 8'b0011_0001, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    #1 checkOutput("frz_y0", 32'(Y), 0);
    nextCycle();
    #1;
    checkOutput("frz_y4_pre", 32'(Y),   4);
    checkOutput("frz_cnt_pre", 32'(Cnt), 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
      #1;
      checkOutput($sformatf("frz_valid%0d", k), 32'(Valid), 0);
      checkOutput($sformatf("frz_y%0d_off", k), 32'(Y), 0);
      checkOutput($sformatf("frz_busy%0d", k), 32'(Busy), 1);
      checkOutput($sformatf("frz_cnt%0d", k), 32'(Cnt), 1);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
    #1;
    checkOutput("frz_y4_post", 32'(Y),     4);
    checkOutput("frz_valid_on", 32'(Valid), 1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    #1;
    checkOutput("frz_y5",  32'(Y),   5);
    checkOutput("frz_cnt2", 32'(Cnt), 2);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    checkOutput("frz_done", 32'(Done), 1);
    checkOutput("frz_cnt",  32'(Cnt),  3);
    checkOutput("frz_busy_end", 32'(Busy), 0);
    nextCycle();
    checkOutput("frz_done_once", 32'(Done), 0);
    checkOutput("frz_cnt_hold",  32'(Cnt),  3);

    // Reset after the first accept, then a single-bit re-load
    applyStimulus(1'b1, 1'b1, 8'b0000_1010, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    #1 checkOutput("rr_y1", 32'(Y), 1);
    nextCycle();
    #1 checkOutput("rr_y3", 32'(Y), 3);
    #1 RST_N = 1'b0;
    #1;
    checkOutput("rr_busy",  32'(Busy),  0);
    checkOutput("rr_valid", 32'(Valid), 0);
    checkOutput("rr_y",     32'(Y),     0);
    checkOutput("rr_cnt",   32'(Cnt),   0);
    checkOutput("rr_done",  32'(Done),  0);
    nextCycle();
    checkOutput("rr_no_done", 32'(Done), 0);
    RST_N = 1'b1;
    nextCycle();
    checkOutput("rr_no_done2", 32'(Done), 0);
    checkOutput("rr_idle",     32'(Busy), 0);
    applyStimulus(1'b1, 1'b1, 8'h04, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    #1;
    checkOutput("rl_y2",    32'(Y),     2);
    checkOutput("rl_valid", 32'(Valid), 1);
    nextCycle();
    checkOutput("rl_done",  32'(Done),  1);
    checkOutput("rl_cnt",   32'(Cnt),   1);
    checkOutput("rl_valid_end", 32'(Valid), 0);

    // 16-bit instance, 16'h8011; order depends on the priority build
`ifdef PRIO_MSB_FIRST_EN
    y16Exp = '{15, 4, 0};
`else
    y16Exp = '{0, 4, 15};
`endif
    load16 = 1'b1; in16 = 16'h8011; ready16 = 1'b1;
    nextCycle();
    load16 = 1'b0; in16 = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("w16_y%0d", k), 32'(y16), 32'(y16Exp[k]));
      checkOutput($sformatf("w16_valid%0d", k), 32'(valid16), 1);
      nextCycle();
    end
    checkOutput("w16_done",  32'(done16),  1);
    checkOutput("w16_cnt",   32'(cnt16),   3);
    checkOutput("w16_busy",  32'(busy16),  0);
    nextCycle();
    checkOutput("w16_done_end", 32'(done16), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
